usb_line_tx: RTL and testbench
==============================

# usb_line_tx

Full-speed USB line transmitter: turns a byte stream (PID first, then payload) into a complete bus packet on the differential pair. It generates the SYNC field, serializes LSb first, inserts stuffed bits, NRZI-encodes, and terminates with EOP. It sits between the SIE transmit-side packet logic and `usb_dp`, and drives the data and output-enable registers of the pair. It is the transmit counterpart of the receive path.

## Interface
- `BIT_CYCLES`, default 4: clk48 cycles per 12 Mbit/s bit time.
- `clk48` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `reqSendPacket` in 1: start a packet; sampled only in IDLE.
- `txData` in 8: byte to send; the first byte is the PID byte.
- `txDataValid` in 1: `txData` holds a new byte.
- `txIsLastByte` in 1: qualifies `txData` as the final byte.
- `txAcceptNewData` out 1: the holding register can take a byte.
- `sending` out 1: a packet is in progress.
- `txUnderrun` out 1: one-cycle pulse when a packet is aborted for lack of data.
- `dataOutP_reg`, `dataOutN_reg` out 1 each: registered line levels.
- `outEN_reg` out 1: drives the pair's output enable.

## Operation
- Line states:
  - J: P=1, N=0.
  - K: P=0, N=1.
  - SE0: P=0, N=0.
  - Idle line is J.
- State machine, as `tx_state_t`:
  - IDLE→SYNC when `reqSendPacket`=1.
  - SYNC (8 bits, value 8'h80 sent LSb first, giving KJKJKJKK)→DATA.
  - DATA→CRC when the last byte is done and CRC is enabled, otherwise →EOP_SE0.
  - CRC (16 bits)→EOP_SE0.
  - EOP_SE0 (2 bits)→EOP_J (1 bit)→IDLE.
- Byte handshake:
  - Transfer happens on an edge where `txDataValid && txAcceptNewData`.
  - `txAcceptNewData` = holding register empty AND state ∈ {SYNC, DATA} AND last byte not yet accepted.
  - The holding register loads the shift register at a byte boundary.
- NRZI: data 0 toggles the line (J↔K); data 1 holds the line.
- Bit stuffing:
  - The ones counter counts consecutive 1 bits in SYNC, DATA and CRC.
  - When the counter reaches 6, the next bit time sends a 0 and the shift register does not advance. The counter then clears.
  - A data 0 also clears the counter.
  - A stuffed bit is inserted even when it falls immediately before EOP.
- Underrun:
  - Trigger: the shift register finishes a byte, the holding register is empty, and the last byte has not been accepted.
  - Response: go to EOP_SE0 and pulse `txUnderrun`.
- `outEN_reg`=1 from the first SYNC bit through the end of EOP_J. It is 0 in IDLE.
- `sending`=1 in every state except IDLE.

## Timing
- Reset values:
  - `dataOutP_reg`=1, `dataOutN_reg`=0.
  - `outEN_reg`=0, `sending`=0, `txAcceptNewData`=0, `txUnderrun`=0.
  - State IDLE; ones counter 0; bit-phase counter 0.
- Start latency: `reqSendPacket` sampled high in IDLE at edge n. At edge n+1, `outEN_reg`=1, `sending`=1, and the line is K (the first SYNC bit).
- Bit timing:
  - Every bit, including stuffed bits, is held for exactly `BIT_CYCLES` cycles.
  - Line outputs change only when the bit-phase counter wraps to 0.
- End of packet: the cycle after the last EOP_J cycle, `outEN_reg`=0, `sending`=0, and the state is IDLE.
- `reqSendPacket` asserted while not in IDLE is ignored.
- `rst` mid-packet: all outputs return to their reset values at the next edge. The packet is dropped and no EOP is sent.
- The first byte must arrive within the 32 SYNC cycles; a late first byte causes an underrun.

## Configuration
- `USB_TX_CRC16_EN` defined:
  - CRC16 is appended when the PID byte has `pid[1:0]==2'b11` (DATA PIDs).
  - Parameters: reflected polynomial 16'hA001, init 16'hFFFF, computed over all bytes after the PID.
  - The inverted CRC is sent LSb first, after the last byte.
- `USB_TX_CRC16_EN` undefined: the CRC state is absent and bytes are sent verbatim. Callers supply the CRC bytes themselves.

## Structure
- `sie_defs_pkg` holds:
  - `tx_state_t`;
  - the constants `SYNC_PATTERN`=8'h80, `STUFF_LIMIT`=6, `EOP_SE0_BITS`=2, `CRC16_POLY_REFL`=16'hA001, `CRC16_INIT`=16'hFFFF.
- One sub-module, `usb_crc16_serial`: a bit-serial CRC16 with clear and shift-enable inputs. It is instantiated only under `USB_TX_CRC16_EN`.

## Test plan
- Reset: hold `rst` for 3 cycles → P=1, N=0, `outEN_reg`=0, `sending`=0, `txAcceptNewData`=0.
- ACK packet: request, then byte 0xD2 with last=1 → line sequence KJKJKJKK, then the PID bits 0,1,0,0,1,0,1,1 NRZI-encoded, then SE0, SE0, J. `sending` is high for exactly 76 cycles.
- Stuffing, macro off: DATA0 PID 0xC3 followed by 0xFF (last) → exactly one stuffed bit, after the 4th bit of 0xFF. Packet lasts 28 bits = 112 cycles.
- CRC, macro on: zero-length DATA0 (0xC3, last) → 16 zero bits (CRC 0x0000) before EOP. Packet lasts 35 bits = 140 cycles.
- Underrun: PID 0xC3 then `txDataValid` held low → `txUnderrun` pulses once when the PID byte completes, then SE0, SE0, J, then IDLE.
- Reset mid-packet: assert `rst` during DATA → next edge `outEN_reg`=0 and the line is J. A new `reqSendPacket` then starts a clean SYNC.

Source files
------------

// File: rtl/sie_defs_pkg.sv
// rtl/sie_defs_pkg.sv - shared transmit-path types and constants (USB_TX_CRC16_EN adds the CRC state)
package sie_defs_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
`ifdef USB_TX_CRC16_EN
        CRC     = 3'd3,
`endif
        EOP_SE0 = 3'd4,
        EOP_J   = 3'd5
    } tx_state_t;

    localparam logic [7:0]  SYNC_PATTERN    = 8'h80;
    localparam int          STUFF_LIMIT     = 6;
    localparam int          EOP_SE0_BITS    = 2;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

endpackage

// File: rtl/usb_crc16_serial.sv
// rtl/usb_crc16_serial.sv - bit-serial reflected CRC16, LSb-first input
module usb_crc16_serial import sie_defs_pkg::*; (
    input  logic        clk48,
    input  logic        rst,
    input  logic        clear,
    input  logic        shiftEn,
    input  logic        dataBit,
    output logic [15:0] crc
);

    logic feedback;

    assign feedback = crc[0] ^ dataBit;

    // Shift one data bit into the reflected CRC; clear reloads the seed
    always_ff @(posedge clk48) begin
        if (rst || clear) begin
            crc <= CRC16_INIT;
        end else if (shiftEn) begin
            crc <= (crc >> 1) ^ (feedback ? CRC16_POLY_REFL : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_line_tx.sv
// rtl/usb_line_tx.sv - full-speed USB line transmitter: SYNC, stuffing, NRZI, EOP (USB_TX_CRC16_EN appends CRC16)
module usb_line_tx import sie_defs_pkg::*; #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk48,
    input  logic       rst,
    input  logic       reqSendPacket,
    input  logic [7:0] txData,
    input  logic       txDataValid,
    input  logic       txIsLastByte,
    output logic       txAcceptNewData,
    output logic       sending,
    output logic       txUnderrun,
    output logic       dataOutP_reg,
    output logic       dataOutN_reg,
    output logic       outEN_reg
);

    localparam int            PW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(BIT_CYCLES - 1);
    localparam logic [3:0]    SE0_LAST   = 4'(EOP_SE0_BITS - 1);
    localparam logic [2:0]    STUFF_AT   = 3'(STUFF_LIMIT);

    tx_state_t     state;
    tx_state_t     nextState;
    logic [PW-1:0] phase;
    logic [3:0]    bitIdx;
    logic [3:0]    nextIdx;
    logic [3:0]    idxInc;
    logic [2:0]    onesCnt;
    logic [7:0]    shiftReg;
    logic [7:0]    holdReg;
    logic          holdFull;
    logic          holdLast;
    logic          shiftIsLast;
    logic          lastAccepted;
    logic          tick;
    logic          stuffField;
    logic          lineUpdate;
    logic          emitBit;
    logic          emitStuff;
    logic          emitSe0;
    logic          emitJ;
    logic          loadShift;
    logic          underrunNow;
    logic          startPkt;

`ifdef USB_TX_CRC16_EN
    logic [15:0]   crcVal;
    logic          isPid;
    logic          pidNext;
    logic          crcActive;
    logic          crcShift;

    usb_crc16_serial uCrc (
        .clk48   (clk48),
        .rst     (rst),
        .clear   (startPkt),
        .shiftEn (crcShift),
        .dataBit (emitBit),
        .crc     (crcVal)
    );
`endif

    assign idxInc          = bitIdx + 4'd1;
    assign tick            = (phase == PHASE_LAST);
    assign sending         = (state != IDLE);
    assign txAcceptNewData = !holdFull && !lastAccepted && ((state == SYNC) || (state == DATA));
`ifdef USB_TX_CRC16_EN
    assign stuffField      = (state == SYNC) || (state == DATA) || (state == CRC);
`else
    assign stuffField      = (state == SYNC) || (state == DATA);
`endif

    // State register
    always_ff @(posedge clk48) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Choose the next bit on the line at each bit boundary; stuffing pre-empts field progress
    always_comb begin
        nextState   = state;
        nextIdx     = bitIdx;
        lineUpdate  = 1'b0;
        emitBit     = 1'b1;
        emitStuff   = 1'b0;
        emitSe0     = 1'b0;
        emitJ       = 1'b0;
        loadShift   = 1'b0;
        underrunNow = 1'b0;
        startPkt    = 1'b0;
        case (state)
            IDLE: begin
                if (reqSendPacket) begin
                    nextState  = SYNC;
                    nextIdx    = 4'd0;
                    lineUpdate = 1'b1;
                    startPkt   = 1'b1;
                    emitBit    = SYNC_PATTERN[0];
                end
            end
            default: begin
                if (tick) begin
                    lineUpdate = 1'b1;
                    if (stuffField && (onesCnt == STUFF_AT)) begin
                        emitStuff = 1'b1;
                        emitBit   = 1'b0;
                    end else begin
                        case (state)
                            SYNC: begin
                                if (bitIdx != 4'd7) begin
                                    nextIdx = idxInc;
                                    emitBit = SYNC_PATTERN[idxInc[2:0]];
                                end else if (holdFull) begin
                                    nextState = DATA;
                                    nextIdx   = 4'd0;
                                    loadShift = 1'b1;
                                    emitBit   = holdReg[0];
                                end else begin
                                    underrunNow = 1'b1;
                                end
                            end
                            DATA: begin
                                if (bitIdx != 4'd7) begin
                                    nextIdx = idxInc;
                                    emitBit = shiftReg[idxInc[2:0]];
                                end else if (shiftIsLast) begin
`ifdef USB_TX_CRC16_EN
                                    if (crcActive) begin
                                        nextState = CRC;
                                        nextIdx   = 4'd0;
                                        emitBit   = ~crcVal[0];
                                    end else
`endif
                                    begin
                                        nextState = EOP_SE0;
                                        nextIdx   = 4'd0;
                                        emitSe0   = 1'b1;
                                    end
                                end else if (holdFull) begin
                                    nextIdx   = 4'd0;
                                    loadShift = 1'b1;
                                    emitBit   = holdReg[0];
                                end else begin
                                    underrunNow = 1'b1;
                                end
                            end
`ifdef USB_TX_CRC16_EN
                            CRC: begin
                                if (bitIdx != 4'd15) begin
                                    nextIdx = idxInc;
                                    emitBit = ~crcVal[idxInc];
                                end else begin
                                    nextState = EOP_SE0;
                                    nextIdx   = 4'd0;
                                    emitSe0   = 1'b1;
                                end
                            end
`endif
                            EOP_SE0: begin
                                if (bitIdx != SE0_LAST) begin
                                    nextIdx = idxInc;
                                    emitSe0 = 1'b1;
                                end else begin
                                    nextState = EOP_J;
                                    nextIdx   = 4'd0;
                                    emitJ     = 1'b1;
                                end
                            end
                            default: begin
                                nextState = IDLE;
                                nextIdx   = 4'd0;
                                emitJ     = 1'b1;
                            end
                        endcase
                        if (underrunNow) begin
                            nextState = EOP_SE0;
                            nextIdx   = 4'd0;
                            emitSe0   = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // Bit-phase counter, bit index, ones counter and NRZI-encoded line registers
    always_ff @(posedge clk48) begin
        if (rst) begin
            phase        <= '0;
            bitIdx       <= 4'd0;
            onesCnt      <= 3'd0;
            dataOutP_reg <= 1'b1;
            dataOutN_reg <= 1'b0;
            outEN_reg    <= 1'b0;
            txUnderrun   <= 1'b0;
        end else begin
            txUnderrun <= underrunNow;
            bitIdx     <= nextIdx;
            if ((state == IDLE) || tick) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
            if (lineUpdate) begin
                outEN_reg <= (nextState != IDLE);
                if (emitSe0) begin
                    dataOutP_reg <= 1'b0;
                    dataOutN_reg <= 1'b0;
                end else if (emitJ) begin
                    dataOutP_reg <= 1'b1;
                    dataOutN_reg <= 1'b0;
                end else if (!emitBit) begin
                    dataOutP_reg <= ~dataOutP_reg;
                    dataOutN_reg <= dataOutP_reg;
                end
                if (emitStuff || emitSe0 || emitJ || !emitBit) begin
                    onesCnt <= 3'd0;
                end else begin
                    onesCnt <= onesCnt + 3'd1;
                end
            end
        end
    end

    // Holding register accepts bytes; the shift register takes it at each byte boundary
    always_ff @(posedge clk48) begin
        if (rst) begin
            holdReg      <= 8'h00;
            shiftReg     <= 8'h00;
            holdFull     <= 1'b0;
            holdLast     <= 1'b0;
            shiftIsLast  <= 1'b0;
            lastAccepted <= 1'b0;
        end else if (startPkt) begin
            holdFull     <= 1'b0;
            shiftIsLast  <= 1'b0;
            lastAccepted <= 1'b0;
        end else if (loadShift) begin
            shiftReg    <= holdReg;
            shiftIsLast <= holdLast;
            holdFull    <= 1'b0;
        end else if (txDataValid && txAcceptNewData) begin
            holdReg      <= txData;
            holdLast     <= txIsLastByte;
            holdFull     <= 1'b1;
            lastAccepted <= txIsLastByte;
        end
    end

`ifdef USB_TX_CRC16_EN
    // The PID byte is excluded from the CRC; only DATA PIDs get a CRC appended
    always_comb begin
        pidNext = isPid;
        if (loadShift) begin
            pidNext = (state == SYNC);
        end
        crcShift = lineUpdate && (nextState == DATA) && !emitStuff && !pidNext;
    end

    // Track whether the byte on the wire is the PID and whether this packet carries a CRC
    always_ff @(posedge clk48) begin
        if (rst || startPkt) begin
            isPid     <= 1'b0;
            crcActive <= 1'b0;
        end else if (loadShift) begin
            isPid <= pidNext;
            if (state == SYNC) begin
                crcActive <= (holdReg[1:0] == 2'b11);
            end
        end
    end
`endif

endmodule

// File: tb/tb_usb_line_tx.sv
// tb/tb_usb_line_tx.sv - scoreboard bench for usb_line_tx
module tb_usb_line_tx;

    localparam int BC = 4;

    logic       clk48 = 1'b0;
    logic       rst;
    logic       reqSendPacket;
    logic [7:0] txData;
    logic       txDataValid;
    logic       txIsLastByte;
    logic       txAcceptNewData;
    logic       sending;
    logic       txUnderrun;
    logic       dataOutP_reg;
    logic       dataOutN_reg;
    logic       outEN_reg;

    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] expQ[$];
    int         lenQ[$];
    bit         monIgnore = 1'b0;
    int         underrunCycles = 0;
    bit         inPkt = 1'b0;
    int         cyc = 0;
    int         base;

    always #5 clk48 = ~clk48;

    usb_line_tx #(.BIT_CYCLES(BC)) dut (
        .clk48           (clk48),
        .rst             (rst),
        .reqSendPacket   (reqSendPacket),
        .txData          (txData),
        .txDataValid     (txDataValid),
        .txIsLastByte    (txIsLastByte),
        .txAcceptNewData (txAcceptNewData),
        .sending         (sending),
        .txUnderrun      (txUnderrun),
        .dataOutP_reg    (dataOutP_reg),
        .dataOutN_reg    (dataOutN_reg),
        .outEN_reg       (outEN_reg)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic pushPkt(input string s, input int cycles);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "J") expQ.push_back(2'b10);
            else if (s[i] == "K") expQ.push_back(2'b01);
            else expQ.push_back(2'b00);
        end
        lenQ.push_back(cycles);
    endtask

    task automatic startReq();
        @(negedge clk48);
        reqSendPacket = 1'b1;
        @(posedge clk48);
        #1;
        reqSendPacket = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic last);
        int n = 0;
        @(negedge clk48);
        txData       = b;
        txIsLastByte = last;
        txDataValid  = 1'b1;
        while (!txAcceptNewData && n < 400) begin
            @(negedge clk48);
            n++;
        end
        check("byte_accepted", int'(n < 400), 1);
        @(posedge clk48);
        #1;
        txDataValid  = 1'b0;
        txIsLastByte = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (sending && n < 2000) begin
            @(negedge clk48);
            n++;
        end
        check("packet_ends", int'(n < 2000), 1);
        @(posedge clk48);
        #1;
    endtask

    // Monitor: compare each bit time against the scoreboard, then the packet length
    initial begin : monitor
        logic [1:0] e;
        forever begin
            @(negedge clk48);
            if (txUnderrun) underrunCycles++;
            if (sending) begin
                if (!inPkt) begin
                    inPkt = 1'b1;
                    cyc   = 0;
                end
                if (!monIgnore && (cyc % BC) == 0) begin
                    if (expQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_bit: got line %b%b required none", dataOutP_reg, dataOutN_reg);
                    end else begin
                        e = expQ.pop_front();
                        check($sformatf("line_bit%0d", cyc / BC),
                              int'({outEN_reg, dataOutP_reg, dataOutN_reg}), int'({1'b1, e}));
                    end
                end
                cyc++;
            end else if (inPkt) begin
                inPkt = 1'b0;
                if (!monIgnore) begin
                    if (lenQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_packet: got %0d cycles required none", cyc);
                    end else begin
                        check("pkt_cycles", cyc, lenQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst           = 1'b1;
        reqSendPacket = 1'b0;
        txData        = 8'h00;
        txDataValid   = 1'b0;
        txIsLastByte  = 1'b0;
        repeat (3) @(posedge clk48);
        #1;
        check("rst_P", int'(dataOutP_reg), 1);
        check("rst_N", int'(dataOutN_reg), 0);
        check("rst_outEN", int'(outEN_reg), 0);
        check("rst_sending", int'(sending), 0);
        check("rst_accept", int'(txAcceptNewData), 0);
        check("rst_underrun", int'(txUnderrun), 0);
        @(negedge clk48);
        rst = 1'b0;

        // ACK handshake packet
        pushPkt({"KJKJKJKK", "JJKJJKKK", "00J"}, 76);
        startReq();
        sendByte(8'hD2, 1'b1);
        waitIdle();
        check("ack_no_underrun", underrunCycles, 0);

        // Stuffed bit just before EOP, with a stray request mid-packet
        pushPkt({"KJKJKJKK", "JJKJJKKK", "JKKKKKKK", "J", "00J"}, 112);
        startReq();
        sendByte(8'hD2, 1'b0);
        sendByte(8'hFC, 1'b1);
        repeat (20) @(negedge clk48);
        startReq();
        waitIdle();

`ifdef USB_TX_CRC16_EN
        // Zero-length DATA0: inverted CRC of nothing is all zeros
        pushPkt({"KJKJKJKK", "KKJKJKKK", "JKJKJKJKJKJKJKJK", "00J"}, 140);
        startReq();
        sendByte(8'hC3, 1'b1);
        waitIdle();
`else
        // DATA0 with 0xFF: one stuffed bit after the fourth payload bit
        pushPkt({"KJKJKJKK", "KKJKJKKK", "KKKKJJJJJ", "00J"}, 112);
        startReq();
        sendByte(8'hC3, 1'b0);
        sendByte(8'hFF, 1'b1);
        waitIdle();
`endif

        // Underrun after the PID byte
        base = underrunCycles;
        pushPkt({"KJKJKJKK", "KKJKJKKK", "00J"}, 76);
        startReq();
        sendByte(8'hC3, 1'b0);
        waitIdle();
        check("underrun_pulse", underrunCycles - base, 1);

        // Reset in the middle of DATA, then a clean packet
        base = underrunCycles;
        monIgnore = 1'b1;
        startReq();
        sendByte(8'hC3, 1'b0);
        repeat (40) @(negedge clk48);
        check("pre_reset_sending", int'(sending), 1);
        rst = 1'b1;
        @(posedge clk48);
        #1;
        check("midrst_outEN", int'(outEN_reg), 0);
        check("midrst_P", int'(dataOutP_reg), 1);
        check("midrst_N", int'(dataOutN_reg), 0);
        check("midrst_sending", int'(sending), 0);
        @(negedge clk48);
        rst = 1'b0;
        @(posedge clk48);
        #1;
        monIgnore = 1'b0;
        check("midrst_no_underrun", underrunCycles - base, 0);
        pushPkt({"KJKJKJKK", "JJKJJKKK", "00J"}, 76);
        startReq();
        sendByte(8'hD2, 1'b1);
        waitIdle();

        repeat (4) @(posedge clk48);
        check("expq_drained", expQ.size(), 0);
        check("lenq_drained", lenQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
